// File: rtl/cpu_pkg.sv
// CPU memory-bus types shared by the CPU, the memory responder and the DMA.
// MemC is the master-to-responder request; MemR carries read data back
// (valid the cycle after a read request). Also holds the DMA state encoding.
package cpu_pkg;

  typedef struct packed {
    logic        sel;  // request valid this cycle
    logic        wr;   // 1 = write, 0 = read
    logic        bsy;  // master-side stall indication (DMA never stalls)
    logic [3:0]  be;   // byte enables
    logic [31:0] a;    // byte address
    logic [31:0] d;    // write data
  } MemC;

  typedef struct packed {
    logic [31:0] q;    // read data
  } MemR;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    CAP,
    WR,
    DONE
  } DmaState;

  localparam logic [3:0] DMA_BE_WORD = 4'hF;

  // Full-word request with write data left at 0; data is overlaid by the caller.
  function automatic MemC dma_req(input logic wr, input logic [31:0] a);
    MemC r;
    r     = '0;
    r.sel = 1'b1;
    r.wr  = wr;
    r.be  = DMA_BE_WORD;
    r.a   = a;
    return r;
  endfunction

endpackage

// File: rtl/mem_dma.sv
// Word-copy DMA master on the CPU memory bus: RD -> CAP -> WR per word, one word per 3 cycles.
// Latency: start at cycle 0 gives first read at cycle 1 and done at cycle 3N+1 (len=0: cycle 1).
// No bus backpressure; abort returns to IDLE next cycle. Optional MEM_DMA_FILL_EN adds a WR-only fill mode.
module mem_dma
  import cpu_pkg::*;
#(
  parameter int AW = 18,
  parameter int LW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [31:0]   src,
  input  logic [31:0]   dst,
  input  logic [LW-1:0] len,
  input  logic          abort,
`ifdef MEM_DMA_FILL_EN
  input  logic          fill,
  input  logic [31:0]   fill_data,
`endif
  output logic          busy,
  output logic          done,
  output logic [LW-1:0] remaining,
  output MemC           memc,
  input  MemR           memr
);

  DmaState       state_q;
  logic [31:0]   src_q;
  logic [31:0]   dst_q;
  logic [31:0]   buf_q;
  logic [LW-1:0] rem_q;
  logic          busy_q;
  logic          done_q;
  MemC           memc_q;
  logic          fill_q;

  // Address low bits are forced to word alignment; the responder alone applies AW.
  logic unused_bits;
  assign unused_bits = ^{src[1:0], dst[1:0], (AW > 0)};

`ifndef MEM_DMA_FILL_EN
  assign fill_q = 1'b0;
`endif

  // Sequencer: state, pointers, staging buffer and registered bus/status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      buf_q   <= '0;
      rem_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      memc_q  <= '0;
`ifdef MEM_DMA_FILL_EN
      fill_q  <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      memc_q <= '0;
      if (abort && state_q != IDLE) begin
        // Pointers and count are frozen; any write already on the bus still lands.
        state_q <= IDLE;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (start) begin
              if (len != '0) begin
                src_q  <= {src[31:2], 2'b00};
                dst_q  <= {dst[31:2], 2'b00};
                rem_q  <= len;
                busy_q <= 1'b1;
`ifdef MEM_DMA_FILL_EN
                fill_q <= fill;
                if (fill) begin
                  buf_q   <= fill_data;
                  state_q <= WR;
                  memc_q  <= dma_req(1'b1, {dst[31:2], 2'b00});
                end else begin
                  state_q <= RD;
                  memc_q  <= dma_req(1'b0, {src[31:2], 2'b00});
                end
`else
                state_q <= RD;
                memc_q  <= dma_req(1'b0, {src[31:2], 2'b00});
`endif
              end else begin
                state_q <= DONE;
                done_q  <= 1'b1;
              end
            end
          end
          RD: begin
            state_q <= CAP;
          end
          CAP: begin
            buf_q   <= memr.q;
            state_q <= WR;
            memc_q  <= dma_req(1'b1, dst_q);
          end
          WR: begin
            src_q <= src_q + 32'd4;
            dst_q <= dst_q + 32'd4;
            rem_q <= rem_q - 1'b1;
            if (rem_q == LW'(1)) begin
              state_q <= DONE;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
            end else if (fill_q) begin
              state_q <= WR;
              memc_q  <= dma_req(1'b1, dst_q + 32'd4);
            end else begin
              state_q <= RD;
              memc_q  <= dma_req(1'b0, src_q + 32'd4);
            end
          end
          DONE: begin
            state_q <= IDLE;
          end
          default: begin
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

  // Write data comes straight from the staging register so d is 0 whenever no write is issued.
  always_comb begin
    memc = memc_q;
    if (memc_q.sel && memc_q.wr) begin
      memc.d = buf_q;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign remaining = rem_q;

endmodule
